// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32 opcode, immediate-kind and occupancy definitions
package rv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // addi x0,x0,0 : what decode sees while the stage is empty
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM_I    = 2'd1,
    IMM_S    = 2'd2,
    IMM_B    = 2'd3
  } imm_kind_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/imm12_field_sel.sv
// rtl/imm12_field_sel.sv - raw 12-bit immediate field selector for I/S/B formats
module imm12_field_sel
  import rv_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [11:0] imm12_o,
  output imm_kind_e   imm_kind_o
);

  // Pick the immediate bits by opcode; B drops implied bit 0, consumer shifts it back
  always_comb begin
    imm12_o    = 12'h000;
    imm_kind_o = IMM_NONE;
    case (instr_i[6:0])
      OP_LOAD, OP_IMM, OP_JALR: begin
        imm12_o    = instr_i[31:20];
        imm_kind_o = IMM_I;
      end
      OP_STORE: begin
        imm12_o    = {instr_i[31:25], instr_i[11:7]};
        imm_kind_o = IMM_S;
      end
      OP_BRANCH: begin
        imm12_o    = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8]};
        imm_kind_o = IMM_B;
      end
      default: begin
        imm12_o    = 12'h000;
        imm_kind_o = IMM_NONE;
      end
    endcase
  end

endmodule

// File: rtl/fetch_decode_reg.sv
// rtl/fetch_decode_reg.sv - fetch-to-decode register with 2-entry skid buffer and flush
module fetch_decode_reg #(
  parameter int                XLEN      = 32,
  parameter logic [XLEN-1:0]   NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [11:0]     out_imm12,
  output logic [1:0]      out_imm_kind
);
  import rv_pkg::*;

  occ_e            occ_q;
  logic            in_ready_q;

  logic [XLEN-1:0] main_instr_q;
  logic [XLEN-1:0] main_pc_q;
  logic [11:0]     main_imm12_q;
  imm_kind_e       main_kind_q;

  logic [XLEN-1:0] skid_instr_q;
  logic [XLEN-1:0] skid_pc_q;
  logic [11:0]     skid_imm12_q;
  imm_kind_e       skid_kind_q;

  logic [11:0]     in_imm12;
  imm_kind_e       in_kind;
  logic            accept;

  imm12_field_sel u_imm_sel (
    .instr_i    (in_instr[31:0]),
    .imm12_o    (in_imm12),
    .imm_kind_o (in_kind)
  );

  assign accept = in_valid && in_ready_q;

  // Occupancy FSM; main entry is always the oldest, empty slots hold reset values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      occ_q        <= OCC_EMPTY;
      in_ready_q   <= 1'b1;
      main_instr_q <= NOP_INSTR;
      main_pc_q    <= '0;
      main_imm12_q <= '0;
      main_kind_q  <= IMM_NONE;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
      skid_imm12_q <= '0;
      skid_kind_q  <= IMM_NONE;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (accept) begin
            main_instr_q <= in_instr;
            main_pc_q    <= in_pc;
            main_imm12_q <= in_imm12;
            main_kind_q  <= in_kind;
            occ_q        <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (accept && out_ready) begin
            main_instr_q <= in_instr;
            main_pc_q    <= in_pc;
            main_imm12_q <= in_imm12;
            main_kind_q  <= in_kind;
          end else if (accept) begin
            skid_instr_q <= in_instr;
            skid_pc_q    <= in_pc;
            skid_imm12_q <= in_imm12;
            skid_kind_q  <= in_kind;
            occ_q        <= OCC_TWO;
            in_ready_q   <= 1'b0;
          end else if (out_ready) begin
            main_instr_q <= NOP_INSTR;
            main_pc_q    <= '0;
            main_imm12_q <= '0;
            main_kind_q  <= IMM_NONE;
            occ_q        <= OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (out_ready) begin
            main_instr_q <= skid_instr_q;
            main_pc_q    <= skid_pc_q;
            main_imm12_q <= skid_imm12_q;
            main_kind_q  <= skid_kind_q;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= '0;
            skid_imm12_q <= '0;
            skid_kind_q  <= IMM_NONE;
            occ_q        <= OCC_ONE;
            in_ready_q   <= 1'b1;
          end
        end
        default: begin
          occ_q      <= OCC_EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = (occ_q != OCC_EMPTY);
  assign out_instr    = main_instr_q;
  assign out_pc       = main_pc_q;
  assign out_imm12    = main_imm12_q;
  assign out_imm_kind = main_kind_q;

endmodule

// File: tb/tb_fetch_decode_reg.sv
// tb/tb_fetch_decode_reg.sv - directed self-checking bench for fetch_decode_reg
module tb_fetch_decode_reg;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [11:0] out_imm12;
  logic [1:0]  out_imm_kind;

  int total;
  int bad;

  fetch_decode_reg dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .out_imm12    (out_imm12),
    .out_imm_kind (out_imm_kind)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  task automatic chk_empty(input string tag);
    chk({tag, ".valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, ".ready"}, {31'b0, in_ready}, 32'd1);
    chk({tag, ".instr"}, out_instr, 32'h0000_0013);
    chk({tag, ".pc"}, out_pc, 32'd0);
    chk({tag, ".imm"}, {20'b0, out_imm12}, 32'd0);
    chk({tag, ".kind"}, {30'b0, out_imm_kind}, 32'd0);
  endtask

  task automatic chk_out(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [11:0] imm, input logic [1:0] kind);
    chk({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, ".instr"}, out_instr, ins);
    chk({tag, ".pc"}, out_pc, pc);
    chk({tag, ".imm"}, {20'b0, out_imm12}, {20'b0, imm});
    chk({tag, ".kind"}, {30'b0, out_imm_kind}, {30'b0, kind});
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h02D0_0093;
    in_pc     = 32'h0000_0040;
    flush     = 1'b0;
    out_ready = 1'b0;

    // reset held with in_valid high
    step();
    step();
    chk_empty("rst");

    // release between edges: nothing accepted before an edge
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_empty("rel");

    // flush right after reset with in_valid high
    in_valid = 1'b1;
    flush    = 1'b1;
    step();
    chk_empty("flush0");
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    chk_empty("idle");

    // I-type stream at full rate
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h02D0_0093;
    in_pc     = 32'h0000_0100;
    step();
    chk_out("i0", 32'h02D0_0093, 32'h100, 12'h02D, 2'd1);
    chk("i0.ext", sext12(out_imm12), 32'd45);
    chk("i0.rdy", {31'b0, in_ready}, 32'd1);
    in_instr = 32'hFFF0_0113;
    in_pc    = 32'h0000_0104;
    step();
    chk_out("i1", 32'hFFF0_0113, 32'h104, 12'hFFF, 2'd1);
    chk("i1.ext", sext12(out_imm12), 32'hFFFF_FFFF);

    // S / B / U formats
    in_instr = 32'h7E50_2FA3;
    in_pc    = 32'h0000_0108;
    step();
    chk_out("s", 32'h7E50_2FA3, 32'h108, 12'h7FF, 2'd2);
    in_instr = 32'h0E00_0D63;
    in_pc    = 32'h0000_010C;
    step();
    chk_out("b", 32'h0E00_0D63, 32'h10C, 12'h07D, 2'd3);
    in_instr = 32'h0000_0037;
    in_pc    = 32'h0000_0110;
    step();
    chk_out("lui", 32'h0000_0037, 32'h110, 12'h000, 2'd0);
    in_valid = 1'b0;
    step();
    chk_empty("drain");

    // back-pressure: A, B fill the stage, C is held off
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h0010_0093;
    in_pc     = 32'h0000_0200;
    step();
    chk_out("bpA", 32'h0010_0093, 32'h200, 12'h001, 2'd1);
    chk("bpA.rdy", {31'b0, in_ready}, 32'd1);
    in_instr = 32'h0020_0113;
    in_pc    = 32'h0000_0204;
    step();
    chk_out("bpB", 32'h0010_0093, 32'h200, 12'h001, 2'd1);
    chk("bpB.rdy", {31'b0, in_ready}, 32'd0);
    in_instr = 32'h0030_0193;
    in_pc    = 32'h0000_0208;
    step();
    chk_out("bpC", 32'h0010_0093, 32'h200, 12'h001, 2'd1);
    chk("bpC.rdy", {31'b0, in_ready}, 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk_out("dqB", 32'h0020_0113, 32'h204, 12'h002, 2'd1);
    chk("dqB.rdy", {31'b0, in_ready}, 32'd1);
    step();
    chk_empty("dq");

    // flush from TWO with in_valid and out_ready both high
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h0010_0093;
    in_pc     = 32'h0000_0300;
    step();
    in_instr = 32'h0020_0113;
    in_pc    = 32'h0000_0304;
    step();
    chk("fl.pre", {31'b0, in_ready}, 32'd0);
    flush     = 1'b1;
    out_ready = 1'b1;
    in_instr  = 32'h0030_0193;
    in_pc     = 32'h0000_0308;
    step();
    chk_empty("fl");
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    chk_empty("fl.post");

    // asynchronous reset while TWO
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h0010_0093;
    in_pc     = 32'h0000_0400;
    step();
    in_instr = 32'h0020_0113;
    in_pc    = 32'h0000_0404;
    step();
    chk("ar.pre", {31'b0, out_valid}, 32'd1);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk_empty("ar");
    rst_n = 1'b1;
    step();
    chk_empty("ar.post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
